// File: rtl/lsu_mem_master_if.sv
// Memory port bundle shared by the load/store unit (master) and the data memory (slave).
// The slave is synchronous: rd_data reflects the rd_addr presented in the previous cycle.
interface mem_intf #(
   parameter int ADDRWIDTH = 32,
   parameter int BUSWIDTH  = 32
);
   logic [ADDRWIDTH-1:0] rd_addr;
   logic [ADDRWIDTH-1:0] wr_addr;
   logic [BUSWIDTH-1:0]  wr_data;
   logic                 wren;
   logic [BUSWIDTH-1:0]  rd_data;

   modport master (output rd_addr, output wr_addr, output wr_data, output wren, input rd_data);
   modport slave  (input rd_addr, input wr_addr, input wr_data, input wren, output rd_data);
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit: byte/half/word requests onto a word-wide memory port without byte enables.
// Sub-word stores are read-modify-write; loads are lane-extracted and sign/zero-extended.
module lsu_mem_master #(
   parameter int ADDRWIDTH = 32,
   parameter int BUSWIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDRWIDTH-1:0] req_addr,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   input  logic [BUSWIDTH-1:0]  req_wdata,
   output logic                 rsp_valid,
   output logic [BUSWIDTH-1:0]  rsp_rdata,
   output logic                 rsp_err,
   mem_intf.master              mem
);

   if (BUSWIDTH != 32) begin : g_buswidth_check
      $error("lsu_mem_master: only BUSWIDTH=32 is supported");
   end

   typedef enum logic [2:0] {
      IDLE,
      RD,
      DATA,
      WR,
      RESP,
      ERR
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   state_e               state;
   state_e               next_state;

   logic                 we_q;
   logic [ADDRWIDTH-1:0] addr_q;
   size_e                size_q;
   logic                 uns_q;
   logic [BUSWIDTH-1:0]  wdata_q;

   logic                 accept;
   logic                 req_err;
   logic [7:0]           byte_lane;
   logic [15:0]          half_lane;
   logic [BUSWIDTH-1:0]  load_ext;
   logic [BUSWIDTH-1:0]  merged;

   assign accept      = req_valid && req_ready;
   assign mem.rd_addr = {addr_q[ADDRWIDTH-1:2], 2'b00};

   always_comb begin
      req_err = 1'b0;
      case (size_e'(req_size))
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
         SZ_BAD:  req_err = 1'b1;
         default: req_err = 1'b0;
      endcase
   end

   always_comb begin
      next_state = state;
      req_ready  = (state == IDLE);
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err)
                  next_state = ERR;
               else if (req_we && size_e'(req_size) == SZ_WORD)
                  next_state = WR;
               else
                  next_state = RD;
            end
         end
         RD:   next_state = DATA;
         DATA: next_state = we_q ? WR : RESP;
         WR:   next_state = IDLE;
         RESP: next_state = IDLE;
         ERR:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Lane selection and merge operate on rd_data, valid only while in DATA.
   always_comb begin
      byte_lane = mem.rd_data[{addr_q[1:0], 3'b000} +: 8];
      half_lane = mem.rd_data[{addr_q[1], 4'b0000} +: 16];
      load_ext  = mem.rd_data;
      merged    = mem.rd_data;
      case (size_q)
         SZ_BYTE: begin
            load_ext = {{(BUSWIDTH-8){~uns_q & byte_lane[7]}}, byte_lane};
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         SZ_HALF: begin
            load_ext = {{(BUSWIDTH-16){~uns_q & half_lane[15]}}, half_lane};
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: begin
            load_ext = mem.rd_data;
            merged   = mem.rd_data;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q        <= 1'b0;
         addr_q      <= '0;
         size_q      <= SZ_BYTE;
         uns_q       <= 1'b0;
         wdata_q     <= '0;
         mem.wren    <= 1'b0;
         mem.wr_addr <= '0;
         mem.wr_data <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         if (accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            size_q      <= size_e'(req_size);
            uns_q       <= req_unsigned;
            wdata_q     <= req_wdata;
            mem.wr_addr <= {req_addr[ADDRWIDTH-1:2], 2'b00};
            mem.wr_data <= req_wdata;
         end else if (state == DATA && we_q) begin
            mem.wr_data <= merged;
         end
         // Outputs are registered, so they are decoded from the state being entered.
         mem.wren  <= (next_state == WR);
         rsp_valid <= (next_state == WR) || (next_state == RESP) || (next_state == ERR);
         rsp_err   <= (next_state == ERR);
         rsp_rdata <= (state == DATA && !we_q) ? load_ext : '0;
      end
   end

endmodule
